// File: rtl/sme_share_bank_if.sv
// Bus bundle for the SME share bank: configuration, register-file style
// read/write ports, RNG handshake and refresh status.
interface sme_share_bank_if #(
  parameter int XLEN  = 32,
  parameter int SMAX  = 4,
  parameter int NREGS = 16,
  parameter int PW    = 16
);
  localparam int NS = SMAX - 1;
  localparam int AW = $clog2(NREGS);

  logic [3:0]         cfg_d;
  logic               cfg_t;
  logic [3:0]         cfg_b;
  logic [AW-1:0]      rs1_addr;
  logic [NS*XLEN-1:0] rs1_rdata;
  logic [AW-1:0]      rs2_addr;
  logic [NS*XLEN-1:0] rs2_rdata;
  logic               res_wen;
  logic [AW-1:0]      res_addr;
  logic [NS*XLEN-1:0] res_wdata;
  logic               bank_wen;
  logic [AW-1:0]      bank_waddr;
  logic [XLEN-1:0]    bank_wdata;
  logic [XLEN-1:0]    bank_rdata;
  logic               bank_conflict;
  logic               refresh_en;
  logic [PW-1:0]      refresh_period;
  logic               rng_valid;
  logic               rng_ready;
  logic [XLEN-1:0]    rng_data;
  logic               refresh_busy;
  logic [15:0]        refresh_count;

  // Functional-unit / RNG side
  modport master (
    output cfg_d, cfg_t, cfg_b, rs1_addr, rs2_addr, res_wen, res_addr, res_wdata,
           bank_wen, bank_waddr, bank_wdata, refresh_en, refresh_period,
           rng_valid, rng_data,
    input  rs1_rdata, rs2_rdata, bank_rdata, bank_conflict, rng_ready,
           refresh_busy, refresh_count
  );

  // Share bank side
  modport slave (
    input  cfg_d, cfg_t, cfg_b, rs1_addr, rs2_addr, res_wen, res_addr, res_wdata,
           bank_wen, bank_waddr, bank_wdata, refresh_en, refresh_period,
           rng_valid, rng_data,
    output rs1_rdata, rs2_rdata, bank_rdata, bank_conflict, rng_ready,
           refresh_busy, refresh_count
  );
endinterface

// File: rtl/sme_share_bank.sv
// Storage for masked-register shares 1..NS with foreground result/bank
// writes and a background engine that re-masks share pairs 1/2.
module sme_share_bank #(
  parameter int XLEN  = 32,
  parameter int SMAX  = 4,
  parameter int NREGS = 16,
  parameter int PW    = 16
) (
  input  logic              g_clk,
  input  logic              g_reset,
  sme_share_bank_if.slave   bus
);
  localparam int NS = SMAX - 1;
  localparam int AW = $clog2(NREGS);
  localparam logic [3:0] NS4 = 4'(NS);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT_RNG, ST_WRITE} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     timer_q, timer_d;
  logic [XLEN-1:0]   mask_q, mask_d;
  logic [15:0]       count_q, count_d;
  logic              conflict_q, conflict_d;
  logic [XLEN-1:0]   mem_q [NREGS][NS];
  logic [XLEN-1:0]   mem_d [NREGS][NS];

  logic              bank_valid;
  logic              bank_ok;
  logic              refresh_block;
  logic              rng_ready_o;
  logic              busy_o;
  logic [XLEN-1:0]   bank_rdata_o;

  assign bank_valid    = (bus.cfg_b != 4'd0) && (bus.cfg_b <= NS4);
  // Result writes take priority; a colliding bank write is dropped.
  assign bank_ok       = bus.bank_wen && bank_valid && !bus.res_wen;
  // Any foreground write to the refresh target defers the refresh a cycle.
  assign refresh_block = (bus.res_wen && (bus.res_addr == ptr_q)) ||
                         (bank_ok && (bus.bank_waddr == ptr_q));
  assign conflict_d    = bus.bank_wen && bank_valid && bus.res_wen;

  // Combinational read ports, share gi+1 in slice gi
  for (genvar gi = 0; gi < NS; gi++) begin : g_rd
    assign bus.rs1_rdata[gi*XLEN +: XLEN] = mem_q[bus.rs1_addr][gi];
    assign bus.rs2_rdata[gi*XLEN +: XLEN] = mem_q[bus.rs2_addr][gi];
  end

  // Bank read: rs2 share selected by cfg_b, zero when out of range
  always_comb begin
    bank_rdata_o = '0;
    for (int b = 0; b < NS; b++) begin
      if (4'(b + 1) == bus.cfg_b) bank_rdata_o = mem_q[bus.rs2_addr][b];
    end
  end

  // FSM state register plus refresh bookkeeping
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      timer_q    <= '0;
      mask_q     <= '0;
      count_q    <= '0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      timer_q    <= timer_d;
      mask_q     <= mask_d;
      count_q    <= count_d;
      conflict_q <= conflict_d;
    end
  end

  // FSM next-state: timer countdown, RNG capture, retry-until-clear write
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    timer_d = timer_q;
    mask_d  = mask_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.refresh_en && (bus.cfg_d >= 4'd3)) begin
          if (timer_q == '0) state_d = ST_WAIT_RNG;
          else               timer_d = timer_q - 1'b1;
        end
      end
      ST_WAIT_RNG: begin
        if (!bus.refresh_en) begin
          state_d = ST_IDLE;
        end else if (bus.rng_valid) begin
          mask_d  = bus.rng_data;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (!refresh_block) begin
          ptr_d   = (ptr_q == AW'(NREGS - 1)) ? '0 : ptr_q + 1'b1;
          timer_d = bus.refresh_period;
          count_d = count_q + 16'd1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    rng_ready_o = (state_q == ST_WAIT_RNG);
    busy_o      = (state_q != ST_IDLE);
  end

  assign bus.rng_ready     = rng_ready_o;
  assign bus.refresh_busy  = busy_o;
  assign bus.refresh_count = count_q;
  assign bus.bank_conflict = conflict_q;
  assign bus.bank_rdata    = bank_rdata_o;

  // Storage next value: foreground writes, then the refresh re-mask of ptr
  always_comb begin
    mem_d = mem_q;
    if (bus.res_wen) begin
      for (int b = 0; b < NS; b++) mem_d[bus.res_addr][b] = bus.res_wdata[b*XLEN +: XLEN];
    end
    if (bank_ok) begin
      for (int b = 0; b < NS; b++) begin
        if (4'(b + 1) == bus.cfg_b) mem_d[bus.bank_waddr][b] = bus.bank_wdata;
      end
    end
    if ((state_q == ST_WRITE) && !refresh_block) begin
      for (int b = 0; b < NS; b++) begin
        if (b == 0) mem_d[ptr_q][b] = bus.cfg_t ? mem_q[ptr_q][b] + mask_q : mem_q[ptr_q][b] ^ mask_q;
        if (b == 1) mem_d[ptr_q][b] = bus.cfg_t ? mem_q[ptr_q][b] - mask_q : mem_q[ptr_q][b] ^ mask_q;
      end
    end
  end

  // Share storage registers
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      for (int r = 0; r < NREGS; r++)
        for (int b = 0; b < NS; b++) mem_q[r][b] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end
endmodule

// File: tb/tb_sme_share_bank.sv
// Scenario bench for sme_share_bank with a queue of expected register contents.
module tb_sme_share_bank;
  localparam int XLEN = 32, SMAX = 4, NREGS = 16, PW = 16;
  localparam int NS = SMAX - 1, AW = 4;

  logic g_clk = 1'b0;
  logic g_reset;
  always #5 g_clk = ~g_clk;

  sme_share_bank_if #(.XLEN(XLEN), .SMAX(SMAX), .NREGS(NREGS), .PW(PW)) bus ();
  sme_share_bank #(.XLEN(XLEN), .SMAX(SMAX), .NREGS(NREGS), .PW(PW)) dut (
    .g_clk(g_clk), .g_reset(g_reset), .bus(bus));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [AW-1:0]      addr;
    logic [NS*XLEN-1:0] data;
  } exp_t;
  exp_t sbq[$];
  exp_t e;
  logic [XLEN-1:0] s1, s2;

  task automatic tick;
    @(posedge g_clk);
    #1;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [NS*XLEN-1:0] d);
    exp_t x;
    x.addr = a;
    x.data = d;
    sbq.push_back(x);
  endtask

  task automatic wait_ready(output bit ok);
    for (int i = 0; i < 40 && !bus.rng_ready; i++) tick();
    ok = bus.rng_ready;
  endtask

  task automatic test_reset;
    g_reset = 1'b1;
    bus.cfg_d = 4'd3; bus.cfg_t = 1'b0; bus.cfg_b = 4'd0;
    bus.rs1_addr = '0; bus.rs2_addr = '0;
    bus.res_wen = 1'b0; bus.res_addr = '0; bus.res_wdata = '0;
    bus.bank_wen = 1'b0; bus.bank_waddr = '0; bus.bank_wdata = '0;
    bus.refresh_en = 1'b0; bus.refresh_period = '0;
    bus.rng_valid = 1'b0; bus.rng_data = '0;
    #2;
    total++;
    if ({bus.rng_ready, bus.refresh_busy, bus.bank_conflict} !== 3'b000 || bus.refresh_count !== 16'd0) begin
      bad++;
      $display("FAIL reset_outputs: got ready/busy/conf=%b%b%b count=%0d want 000 0",
               bus.rng_ready, bus.refresh_busy, bus.bank_conflict, bus.refresh_count);
    end
    tick();
    g_reset = 1'b0;
    tick();
    for (int a = 0; a < NREGS; a++) push(AW'(a), '0);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      bus.rs1_addr = e.addr; #1;
      total++;
      if (bus.rs1_rdata !== e.data) begin
        bad++;
        $display("FAIL reset_storage[%0d]: got %h want %h", e.addr, bus.rs1_rdata, e.data);
      end
    end
    $display("test_reset: done");
  endtask

  task automatic test_result_write;
    bus.res_wen = 1'b1; bus.res_addr = 4'd3;
    bus.res_wdata = {32'h11111111, 32'h0F0F0F0F, 32'hA5A5A5A5};
    tick();
    bus.res_wen = 1'b0;
    for (int a = 0; a < NREGS; a++)
      push(AW'(a), (a == 3) ? {32'h11111111, 32'h0F0F0F0F, 32'hA5A5A5A5} : '0);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      bus.rs1_addr = e.addr; #1;
      total++;
      if (bus.rs1_rdata !== e.data) begin
        bad++;
        $display("FAIL result_write[%0d]: got %h want %h", e.addr, bus.rs1_rdata, e.data);
      end
    end
    $display("test_result_write: done");
  endtask

  task automatic test_refresh_bool;
    bit ok;
    bus.res_wen = 1'b1; bus.res_addr = 4'd0;
    bus.res_wdata = {32'h0, 32'h9ABCDEF0, 32'h12345678};
    tick();
    bus.res_wen = 1'b0;
    bus.cfg_t = 1'b0; bus.refresh_period = '0; bus.rng_data = 32'hFFFF0000;
    bus.refresh_en = 1'b1;
    push(4'd0, {32'h0, 32'h6543DEF0, 32'hEDCB5678});
    wait_ready(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL bool_rng_ready: got 0 want 1"); end
    bus.rng_valid = 1'b1;
    tick();
    bus.rng_valid = 1'b0;
    tick();
    bus.refresh_en = 1'b0;
    total++;
    if (bus.refresh_count !== 16'd1) begin
      bad++; $display("FAIL bool_count: got %0d want 1", bus.refresh_count);
    end
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      bus.rs1_addr = e.addr; #1;
      total++;
      if (bus.rs1_rdata !== e.data) begin
        bad++; $display("FAIL bool_refresh[%0d]: got %h want %h", e.addr, bus.rs1_rdata, e.data);
      end
    end
    s1 = bus.rs1_rdata[31:0]; s2 = bus.rs1_rdata[63:32];
    total++;
    if ((s1 ^ s2) !== (32'h12345678 ^ 32'h9ABCDEF0)) begin
      bad++; $display("FAIL bool_invariant: got %h want %h", s1 ^ s2, 32'h12345678 ^ 32'h9ABCDEF0);
    end
    $display("test_refresh_bool: done");
  endtask

  task automatic test_refresh_arith;
    bit ok;
    bus.res_wen = 1'b1; bus.res_addr = 4'd1;
    bus.res_wdata = {32'h0, 32'd10, 32'd5};
    tick();
    bus.res_wen = 1'b0;
    bus.cfg_t = 1'b1; bus.rng_data = 32'hFFFFFFFF;
    bus.refresh_en = 1'b1;
    push(4'd1, {32'h0, 32'd11, 32'd4});
    wait_ready(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL arith_rng_ready: got 0 want 1"); end
    bus.rng_valid = 1'b1;
    tick();
    bus.rng_valid = 1'b0;
    tick();
    bus.refresh_en = 1'b0;
    total++;
    if (bus.refresh_count !== 16'd2) begin
      bad++; $display("FAIL arith_count: got %0d want 2", bus.refresh_count);
    end
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      bus.rs1_addr = e.addr; #1;
      total++;
      if (bus.rs1_rdata !== e.data) begin
        bad++; $display("FAIL arith_refresh[%0d]: got %h want %h", e.addr, bus.rs1_rdata, e.data);
      end
    end
    s1 = bus.rs1_rdata[31:0]; s2 = bus.rs1_rdata[63:32];
    total++;
    if ((s1 + s2) !== 32'd15) begin
      bad++; $display("FAIL arith_invariant: got %h want %h", s1 + s2, 32'd15);
    end
    bus.cfg_t = 1'b0;
    $display("test_refresh_arith: done");
  endtask

  task automatic test_wait_abort;
    bit ok;
    bus.rng_valid = 1'b0; bus.rng_data = 32'h0BADF00D;
    bus.refresh_en = 1'b1;
    wait_ready(ok);
    for (int i = 0; i < 20; i++) tick();
    total++;
    if (!(bus.rng_ready && bus.refresh_busy)) begin
      bad++; $display("FAIL abort_waiting: got ready=%b busy=%b want 1 1", bus.rng_ready, bus.refresh_busy);
    end
    bus.refresh_en = 1'b0;
    tick();
    total++;
    if (bus.refresh_busy !== 1'b0 || bus.rng_ready !== 1'b0 || bus.refresh_count !== 16'd2) begin
      bad++; $display("FAIL abort_idle: got busy=%b ready=%b count=%0d want 0 0 2",
                      bus.refresh_busy, bus.rng_ready, bus.refresh_count);
    end
    push(4'd0, {32'h0, 32'h6543DEF0, 32'hEDCB5678});
    push(4'd1, {32'h0, 32'd11, 32'd4});
    push(4'd2, '0);
    push(4'd3, {32'h11111111, 32'h0F0F0F0F, 32'hA5A5A5A5});
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      bus.rs1_addr = e.addr; #1;
      total++;
      if (bus.rs1_rdata !== e.data) begin
        bad++; $display("FAIL abort_storage[%0d]: got %h want %h", e.addr, bus.rs1_rdata, e.data);
      end
    end
    $display("test_wait_abort: done");
  endtask

  task automatic test_write_conflict;
    bit ok;
    logic [31:0] m;
    m = 32'h5A5A5A5A;
    bus.cfg_t = 1'b0; bus.rng_data = m;
    bus.refresh_en = 1'b1;
    wait_ready(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL conflict_rng_ready: got 0 want 1"); end
    bus.rng_valid = 1'b1;
    tick();
    bus.rng_valid = 1'b0;
    bus.res_wen = 1'b1; bus.res_addr = 4'd2;
    bus.res_wdata = {32'h33, 32'h2, 32'h1};
    tick();
    bus.res_wen = 1'b0;
    total++;
    if (bus.refresh_busy !== 1'b1) begin
      bad++; $display("FAIL conflict_stays_write: got busy=%b want 1", bus.refresh_busy);
    end
    push(4'd2, {32'h33, 32'h2, 32'h1});
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      bus.rs1_addr = e.addr; #1;
      total++;
      if (bus.rs1_rdata !== e.data) begin
        bad++; $display("FAIL conflict_fg_wins[%0d]: got %h want %h", e.addr, bus.rs1_rdata, e.data);
      end
    end
    tick();
    bus.refresh_en = 1'b0;
    total++;
    if (bus.refresh_busy !== 1'b0 || bus.refresh_count !== 16'd3) begin
      bad++; $display("FAIL conflict_retry_done: got busy=%b count=%0d want 0 3", bus.refresh_busy, bus.refresh_count);
    end
    push(4'd2, {32'h33, 32'h2 ^ m, 32'h1 ^ m});
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      bus.rs1_addr = e.addr; #1;
      total++;
      if (bus.rs1_rdata !== e.data) begin
        bad++; $display("FAIL conflict_retry[%0d]: got %h want %h", e.addr, bus.rs1_rdata, e.data);
      end
    end
    $display("test_write_conflict: done");
  endtask

  task automatic test_bank_conflict;
    bus.cfg_b = 4'd1;
    bus.res_wen = 1'b1; bus.res_addr = 4'd6; bus.res_wdata = {32'hC, 32'hB, 32'hA};
    bus.bank_wen = 1'b1; bus.bank_waddr = 4'd5; bus.bank_wdata = 32'hDEAD;
    tick();
    bus.res_wen = 1'b0; bus.bank_wen = 1'b0;
    total++;
    if (bus.bank_conflict !== 1'b1) begin
      bad++; $display("FAIL bank_conflict_pulse: got %b want 1", bus.bank_conflict);
    end
    tick();
    total++;
    if (bus.bank_conflict !== 1'b0) begin
      bad++; $display("FAIL bank_conflict_width: got %b want 0", bus.bank_conflict);
    end
    bus.cfg_b = 4'd2; bus.bank_wen = 1'b1; bus.bank_waddr = 4'd7; bus.bank_wdata = 32'hBEEF;
    tick();
    bus.cfg_b = 4'd5; bus.bank_wdata = 32'h1234;
    tick();
    bus.bank_wen = 1'b0;
    push(4'd6, {32'hC, 32'hB, 32'hA});
    push(4'd5, '0);
    push(4'd7, {32'h0, 32'hBEEF, 32'h0});
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      bus.rs1_addr = e.addr; #1;
      total++;
      if (bus.rs1_rdata !== e.data) begin
        bad++; $display("FAIL bank_storage[%0d]: got %h want %h", e.addr, bus.rs1_rdata, e.data);
      end
    end
    bus.rs2_addr = 4'd7; bus.cfg_b = 4'd2; #1;
    total++;
    if (bus.bank_rdata !== 32'hBEEF) begin
      bad++; $display("FAIL bank_rdata_sel: got %h want %h", bus.bank_rdata, 32'hBEEF);
    end
    bus.rs2_addr = 4'd6; bus.cfg_b = 4'd0; #1;
    total++;
    if (bus.bank_rdata !== 32'h0) begin
      bad++; $display("FAIL bank_rdata_b0: got %h want 0", bus.bank_rdata);
    end
    bus.cfg_b = 4'd3; #1;
    total++;
    if (bus.bank_rdata !== 32'hC) begin
      bad++; $display("FAIL bank_rdata_b3: got %h want %h", bus.bank_rdata, 32'hC);
    end
    $display("test_bank_conflict: done");
  endtask

  task automatic test_reset_mid_write;
    bit ok;
    bus.rng_data = 32'hCAFEBABE;
    bus.refresh_en = 1'b1;
    wait_ready(ok);
    bus.rng_valid = 1'b1;
    tick();
    bus.rng_valid = 1'b0;
    bus.rs1_addr = 4'd3;
    #2;
    total++;
    if (bus.refresh_busy !== 1'b1) begin
      bad++; $display("FAIL midreset_in_write: got busy=%b want 1", bus.refresh_busy);
    end
    g_reset = 1'b1;
    #1;
    total++;
    if (bus.refresh_busy !== 1'b0 || bus.rng_ready !== 1'b0 || bus.refresh_count !== 16'd0 ||
        bus.bank_conflict !== 1'b0 || bus.rs1_rdata !== '0) begin
      bad++; $display("FAIL midreset_async: got busy=%b ready=%b count=%0d conf=%b rs1=%h want all 0",
                      bus.refresh_busy, bus.rng_ready, bus.refresh_count, bus.bank_conflict, bus.rs1_rdata);
    end
    bus.refresh_en = 1'b0;
    tick();
    g_reset = 1'b0;
    tick();
    push(4'd3, '0);
    push(4'd6, '0);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      bus.rs1_addr = e.addr; #1;
      total++;
      if (bus.rs1_rdata !== e.data) begin
        bad++; $display("FAIL midreset_storage[%0d]: got %h want %h", e.addr, bus.rs1_rdata, e.data);
      end
    end
    $display("test_reset_mid_write: done");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_result_write();
    test_refresh_bool();
    test_refresh_arith();
    test_wait_abort();
    test_write_conflict();
    test_bank_conflict();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
